// File: rtl/cpu_reg_package.sv
// Shared CPU register-map definitions: bus responder identities and timer register layout.
package cpu_reg_package;

  typedef enum logic [1:0] {
    io_e    = 2'd0,
    uart_e  = 2'd1,
    timer_e = 2'd2
  } module_e;

  // Register indices within the timer window (offset = index * Address_Wording).
  localparam logic [2:0] TIMER_CTRL_IDX     = 3'd0;
  localparam logic [2:0] TIMER_PRESCALE_IDX = 3'd1;
  localparam logic [2:0] TIMER_COMPARE_IDX  = 3'd2;
  localparam logic [2:0] TIMER_COUNT_IDX    = 3'd3;
  localparam logic [2:0] TIMER_STATUS_IDX   = 3'd4;
  localparam int unsigned TIMER_NUM_REGS    = 5;

  localparam int unsigned CTRL_EN_BIT       = 0;
  localparam int unsigned CTRL_PERIODIC_BIT = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 2;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale counter: emits a one-cycle tick every (prescale_i+1) enabled cycles.
module timer_prescaler (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic        restart_i,
  input  logic [15:0] prescale_i,
  output logic        tick_o
);

  logic [15:0] pc;

  assign tick_o = en_i && (pc == prescale_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pc <= '0;
    end else if (restart_i || tick_o) begin
      pc <= '0;
    end else if (en_i) begin
      pc <= pc + 16'd1;
    end
  end

endmodule

// File: rtl/timer_cpu.sv
// Memory-mapped timer/compare peripheral with registered read data and level IRQ.
module timer_cpu
  import cpu_reg_package::*;
#(
  parameter longint unsigned BaseAddress     = 0,
  parameter int unsigned     address_width   = 32,
  parameter int unsigned     data_width      = 32,
  parameter int unsigned     Address_Wording = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     rd_wr_i,
  output logic [data_width-1:0]    data_o,
  output logic                     irq_o
);

  logic [2:0]            ctrl;
  logic [15:0]           prescale;
  logic [31:0]           compare;
  logic [31:0]           count;
  logic                  match;
  logic                  hit;
  logic [2:0]            idx;
  logic [data_width-1:0] rd_data;
  logic                  tick;
  logic                  at_compare;
  logic                  wr_ctrl, wr_prescale, wr_compare, wr_count, wr_status;
  logic                  restart;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int unsigned k = 0; k < TIMER_NUM_REGS; k++) begin
      if (address_i == address_width'(BaseAddress + 64'(k) * 64'(Address_Wording))) begin
        hit = 1'b1;
        idx = 3'(k);
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (hit) begin
      case (idx)
        TIMER_CTRL_IDX:     rd_data[2:0]  = ctrl;
        TIMER_PRESCALE_IDX: rd_data[15:0] = prescale;
        TIMER_COMPARE_IDX:  rd_data[31:0] = compare;
        TIMER_COUNT_IDX:    rd_data[31:0] = count;
        TIMER_STATUS_IDX:   rd_data[0]    = match;
        default:            rd_data       = '0;
      endcase
    end
  end

  assign wr_ctrl     = rd_wr_i && hit && (idx == TIMER_CTRL_IDX);
  assign wr_prescale = rd_wr_i && hit && (idx == TIMER_PRESCALE_IDX);
  assign wr_compare  = rd_wr_i && hit && (idx == TIMER_COMPARE_IDX);
  assign wr_count    = rd_wr_i && hit && (idx == TIMER_COUNT_IDX);
  assign wr_status   = rd_wr_i && hit && (idx == TIMER_STATUS_IDX);
  assign restart     = wr_ctrl && data_i[CTRL_EN_BIT] && !ctrl[CTRL_EN_BIT];
  assign at_compare  = (count == compare);

  timer_prescaler u_prescaler (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (ctrl[CTRL_EN_BIT]),
    .restart_i  (restart),
    .prescale_i (prescale),
    .tick_o     (tick)
  );

  // Later assignments take priority: CPU writes override the tick's COUNT/EN
  // updates, and a new match overrides a same-cycle STATUS clear.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ctrl     <= '0;
      prescale <= '0;
      compare  <= '0;
      count    <= '0;
      match    <= 1'b0;
      irq_o    <= 1'b0;
      data_o   <= '0;
    end else begin
      if (wr_status && data_i[0]) match <= 1'b0;
      if (tick) begin
        if (at_compare) begin
          match <= 1'b1;
          if (ctrl[CTRL_PERIODIC_BIT]) count <= '0;
          else                         ctrl[CTRL_EN_BIT] <= 1'b0;
        end else begin
          count <= count + 32'd1;
        end
      end
      if (wr_ctrl)     ctrl     <= data_i[2:0];
      if (wr_prescale) prescale <= data_i[15:0];
      if (wr_compare)  compare  <= data_i[31:0];
      if (wr_count)    count    <= data_i[31:0];
      irq_o  <= match && ctrl[CTRL_IRQ_EN_BIT];
      data_o <= rd_data;
    end
  end

endmodule

// File: tb/tb_timer_cpu.sv
// Directed self-checking bench for timer_cpu with hand-computed expectations.
module tb_timer_cpu;

  localparam logic [31:0] BASE       = 32'h0000_0100;
  localparam logic [31:0] A_CTRL     = BASE + 32'h00;
  localparam logic [31:0] A_PRESCALE = BASE + 32'h04;
  localparam logic [31:0] A_COMPARE  = BASE + 32'h08;
  localparam logic [31:0] A_COUNT    = BASE + 32'h0C;
  localparam logic [31:0] A_STATUS   = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic [31:0] wdata;
  logic        rd_wr;
  logic [31:0] data_o;
  logic        irq_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [31:0] rd;
  logic [31:0] exp_cnt_a [5];
  logic [31:0] exp_cnt_b [8];

  timer_cpu #(
    .BaseAddress     (64'h100),
    .address_width   (32),
    .data_width      (32),
    .Address_Wording (4)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .address_i (address),
    .data_i    (wdata),
    .rd_wr_i   (rd_wr),
    .data_o    (data_o),
    .irq_o     (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] val);
    address = addr;
    wdata   = val;
    rd_wr   = 1'b1;
    step();
    rd_wr   = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] val);
    address = addr;
    rd_wr   = 1'b0;
    step();
    val = data_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_cnt_a = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    exp_cnt_b = '{32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0};
    reset = 1'b1; address = '0; wdata = '0; rd_wr = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    bus_read(A_CTRL, rd);     check("rst_ctrl", rd, 32'd0);
    bus_read(A_PRESCALE, rd); check("rst_prescale", rd, 32'd0);
    bus_read(A_COMPARE, rd);  check("rst_compare", rd, 32'd0);
    bus_read(A_COUNT, rd);    check("rst_count", rd, 32'd0);
    bus_read(A_STATUS, rd);   check("rst_status", rd, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);

    // Periodic, prescale 0, compare 3, IRQ enabled
    bus_write(A_PRESCALE, 32'd0);
    bus_write(A_COMPARE, 32'd3);
    bus_write(A_CTRL, 32'd7);
    for (int i = 0; i < 5; i++) begin
      bus_read(A_COUNT, rd);
      check($sformatf("per_count%0d", i), rd, exp_cnt_a[i]);
      check($sformatf("per_irq%0d", i), 32'(irq_o), (i == 4) ? 32'd1 : 32'd0);
    end
    bus_read(A_STATUS, rd); check("per_match", rd, 32'd1);

    // STATUS clear drops irq next cycle; clear on a new match loses
    bus_write(A_STATUS, 32'd1);
    check("clr_irq_same", 32'(irq_o), 32'd1);
    bus_read(A_STATUS, rd); check("clr_status", rd, 32'd0);
    check("clr_irq_next", 32'(irq_o), 32'd0);
    bus_read(A_COUNT, rd); check("clr_count0", rd, 32'd0);
    bus_read(A_COUNT, rd); check("clr_count1", rd, 32'd1);
    bus_read(A_COUNT, rd); check("clr_count2", rd, 32'd2);
    bus_write(A_STATUS, 32'd1);
    check("race_irq", 32'(irq_o), 32'd1);
    bus_read(A_STATUS, rd); check("race_match", rd, 32'd1);
    check("race_irq_next", 32'(irq_o), 32'd1);

    // One-shot, prescale 2, compare 1, IRQ disabled
    bus_write(A_CTRL, 32'd0);
    bus_write(A_STATUS, 32'd1);
    bus_write(A_COUNT, 32'd0);
    bus_write(A_PRESCALE, 32'd2);
    bus_write(A_COMPARE, 32'd1);
    bus_write(A_CTRL, 32'd1);
    for (int i = 1; i <= 7; i++) begin
      bus_read(A_STATUS, rd);
      if (i >= 6) check($sformatf("os_status%0d", i), rd, (i == 7) ? 32'd1 : 32'd0);
    end
    bus_read(A_CTRL, rd);  check("os_ctrl_en", rd, 32'd0);
    bus_read(A_COUNT, rd); check("os_count", rd, 32'd1);
    check("os_irq", 32'(irq_o), 32'd0);

    // Wrap from 0xFFFFFFFF, then match at 5
    bus_write(A_STATUS, 32'd1);
    bus_write(A_PRESCALE, 32'd0);
    bus_write(A_COMPARE, 32'd5);
    bus_write(A_COUNT, 32'hFFFF_FFFF);
    bus_write(A_CTRL, 32'd3);
    for (int i = 0; i < 8; i++) begin
      bus_read(A_COUNT, rd);
      check($sformatf("wrap_count%0d", i), rd, exp_cnt_b[i]);
    end
    bus_read(A_STATUS, rd); check("wrap_match", rd, 32'd1);
    check("wrap_irq", 32'(irq_o), 32'd0);

    // COUNT write on a tick cycle wins; data_o shows pre-write value
    bus_write(A_COUNT, 32'd10);
    check("wr_prewrite", data_o, 32'd2);
    bus_read(A_COUNT, rd); check("wr_count", rd, 32'd10);

    // Out-of-window, index 5 and misaligned accesses
    bus_write(A_CTRL, 32'd0);
    bus_read(BASE + 32'h20, rd); check("oow_read", rd, 32'd0);
    bus_write(BASE + 32'h20, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h14, 32'hFFFF_FFFF);
    bus_write(BASE + 32'h02, 32'hFFFF_FFFF);
    bus_read(BASE + 32'h02, rd); check("mis_read", rd, 32'd0);
    bus_read(A_CTRL, rd);     check("oow_ctrl", rd, 32'd0);
    bus_read(A_PRESCALE, rd); check("oow_prescale", rd, 32'd0);
    bus_read(A_COMPARE, rd);  check("oow_compare", rd, 32'd5);
    bus_read(A_COUNT, rd);    check("oow_count", rd, 32'd12);
    bus_read(A_STATUS, rd);   check("oow_status", rd, 32'd1);

    // Unused bits read as zero
    bus_write(A_PRESCALE, 32'hFFFF_FFFF);
    bus_read(A_PRESCALE, rd); check("prescale_mask", rd, 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
